constraint_layer_top_mul_pipe_rs: RTL and testbench
===================================================

// Module: constraint_layer_top_mul_pipe_rs
// PURPOSE
//   Pipelined, parametrised multiplier for the constraint-layer datapath.
//   Computes din0*din1 with per-operand signedness, then applies an arithmetic
//   right shift with round-half-up and saturation to DOUT_W.
//   Uses a valid/ready handshake on both sides.
//   Replaces the combinational mul_*_1_1 cores where products are rescaled
//   before accumulation.
// PARAMETERS
//   A_W        14  width of din0
//   B_W        16  width of din1
//   A_SIGNED    0  1: din0 is two's complement; 0: unsigned
//   B_SIGNED    1  1: din1 is two's complement; 0: unsigned
//   NUM_STAGE   2  pipeline register stages, legal range >=1
//   SHIFT       8  fractional bits dropped after the multiply, 0..PW-1
//   DOUT_W     16  output width, signed two's complement, <= PW-SHIFT
// PORTS
//   ap_clk     in   1       clock, all logic on rising edge
//   ap_rst     in   1       synchronous active-high reset
//   in_valid   in   1       din0/din1 carry a valid operand pair
//   in_ready   out  1       block accepts the pair this cycle
//   din0       in   A_W     operand A
//   din1       in   B_W     operand B
//   out_valid  out  1       dout/sat are valid
//   out_ready  in   1       downstream accepts dout this cycle
//   dout       out  DOUT_W  rounded, saturated product
//   sat        out  1       dout was clamped (qualified by out_valid)
// BEHAVIOUR
//   Arithmetic:
//   - PW = A_W+B_W+1.
//   - Each operand is sign- or zero-extended to PW per *_SIGNED.
//   - P = full signed product in PW bits; no overflow is possible.
//   - R = (P + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, using an arithmetic shift.
//     This rounds half toward +inf.
//   - If R > 2^(DOUT_W-1)-1: dout = max, sat = 1.
//   - If R < -2^(DOUT_W-1): dout = min, sat = 1.
//   - Otherwise dout = R[DOUT_W-1:0], sat = 0.
//   Pipeline:
//   - There are NUM_STAGE register stages, each with its own valid bit.
//   - Stage 1 registers the product. Round and saturate complete by stage NUM_STAGE.
//   - adv = !out_valid | out_ready; in_ready = adv. in_ready is combinational,
//     with no dependency on in_valid.
//   - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//   - When adv = 1, every stage shifts forward one place.
//     Stage-1 valid loads in_valid & in_ready.
//   - When adv = 0, all stages hold, including data and valid bits.
//     dout and sat stay stable while out_valid=1 and out_ready=0.
//   - Latency is exactly NUM_STAGE cycles from input transfer to out_valid,
//     provided no stall occurs.
//   - Throughput is 1 pair/cycle with out_ready held high.
//   - Bubbles are not compressed. No data is lost or duplicated.
//   - A simultaneous output transfer and input transfer in the same cycle is
//     legal and required at full rate.
//   Reset:
//   - On a cycle with ap_rst=1, all valid bits are cleared and dout=0, sat=0.
//   - in_ready=1 in the first cycle after reset.
//   - Reset mid-operation discards all in-flight pairs.
//     No out_valid appears for them afterwards.
//   - ap_rst has priority over adv.
//   Checks:
//   - Elaboration fails if NUM_STAGE<1, SHIFT>=PW, or DOUT_W>PW-SHIFT.
// TESTING
//   1. Defaults, din0=256, din1=300, out_ready=1 -> 2 cycles later dout=300, sat=0.
//   2. din1=128/127/-128/-129, each with din0=1 -> dout=1/0/0/-1.
//      This covers half-up rounding, including negative values.
//   3. din0=16383, din1=-32768 -> dout=-32768, sat=1.
//      din0=16383, din1=32767 -> dout=32767, sat=1.
//   4. Stream 8 back-to-back pairs with out_ready=1 -> out_valid high 8
//      consecutive cycles starting at cycle 2. Results in order.
//   5. Drop out_ready for 3 cycles with out_valid=1 -> in_ready=0, dout/sat held.
//      On release, all pairs emerge in order with no loss or duplication.
//   6. Assert ap_rst for 1 cycle with 2 pairs in flight -> out_valid=0, dout=0.
//      No stale output follows; the next pair has normal latency.
//   Also rerun 1-4 with A_SIGNED=1, B_SIGNED=0, NUM_STAGE=1, SHIFT=0, DOUT_W=31.
//   Expect an exact product with sat always 0.

Source files
------------

// File: rtl/constraint_layer_top_mul_pipe_rs_if.sv
// Operand/result handshake bundle for constraint_layer_top_mul_pipe_rs.
// The master drives operands and out_ready; the slave (the multiplier) returns results.
interface constraint_layer_top_mul_pipe_rs_if #(
   parameter int A_W    = 14,
   parameter int B_W    = 16,
   parameter int DOUT_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [A_W-1:0]    din0;
   logic [B_W-1:0]    din1;
   logic              out_valid;
   logic              out_ready;
   logic [DOUT_W-1:0] dout;
   logic              sat;

   modport master (
      output in_valid, din0, din1, out_ready,
      input  in_ready, out_valid, dout, sat
   );

   modport slave (
      input  in_valid, din0, din1, out_ready,
      output in_ready, out_valid, dout, sat
   );
endinterface

// File: rtl/constraint_layer_top_mul_pipe_rs.sv
// Pipelined multiplier with per-operand signedness, round-half-up right shift and
// saturation to a signed DOUT_W result; valid/ready on both sides, global stall.
module constraint_layer_top_mul_pipe_rs #(
   parameter int A_W       = 14,
   parameter int B_W       = 16,
   parameter int A_SIGNED  = 0,
   parameter int B_SIGNED  = 1,
   parameter int NUM_STAGE = 2,
   parameter int SHIFT     = 8,
   parameter int DOUT_W    = 16
) (
   input  logic                              ap_clk,
   input  logic                              ap_rst,
   constraint_layer_top_mul_pipe_rs_if.slave bus
);
   localparam int PW = A_W + B_W + 1;

   // Rounding constant and clamp limits, held one bit wider than the product so
   // adding the half-LSB to an extreme product cannot wrap.
   localparam logic [PW:0]        RND  = ((PW+1)'(1) << SHIFT) >> 1;
   localparam logic signed [PW:0] MAXV = $signed({{(PW+2-DOUT_W){1'b0}}, {(DOUT_W-1){1'b1}}});
   localparam logic signed [PW:0] MINV = ~MAXV;

   if (NUM_STAGE < 1) begin : g_bad_stage
      $error("constraint_layer_top_mul_pipe_rs: NUM_STAGE must be at least 1");
   end
   if (SHIFT >= PW) begin : g_bad_shift
      $error("constraint_layer_top_mul_pipe_rs: SHIFT must be below A_W+B_W+1");
   end
   if (DOUT_W > PW - SHIFT) begin : g_bad_dout
      $error("constraint_layer_top_mul_pipe_rs: DOUT_W exceeds the shifted product width");
   end

   function automatic logic [PW-1:0] extend_a(input logic [A_W-1:0] a);
      if (A_SIGNED != 0) extend_a = {{(PW-A_W){a[A_W-1]}}, a};
      else               extend_a = {{(PW-A_W){1'b0}}, a};
   endfunction

   function automatic logic [PW-1:0] extend_b(input logic [B_W-1:0] b);
      if (B_SIGNED != 0) extend_b = {{(PW-B_W){b[B_W-1]}}, b};
      else               extend_b = {{(PW-B_W){1'b0}}, b};
   endfunction

   // Returns {sat, dout}.
   function automatic logic [DOUT_W:0] round_sat(input logic signed [PW-1:0] p);
      logic signed [PW:0] sum;
      logic signed [PW:0] r;
      sum = {p[PW-1], p} + $signed(RND);
      r   = sum >>> SHIFT;
      if (r > MAXV)      round_sat = {1'b1, MAXV[DOUT_W-1:0]};
      else if (r < MINV) round_sat = {1'b1, MINV[DOUT_W-1:0]};
      else               round_sat = {1'b0, r[DOUT_W-1:0]};
   endfunction

   logic signed [PW-1:0]  prod_s;
   logic                  adv_s;
   logic [NUM_STAGE-1:0]  vld_r;
   logic [DOUT_W:0]       res_s;

   // Full-precision product of the extended operands.
   always_comb begin
      prod_s = $signed(extend_a(bus.din0)) * $signed(extend_b(bus.din1));
   end

   assign adv_s         = ~vld_r[NUM_STAGE-1] | bus.out_ready;
   assign bus.in_ready  = adv_s;
   assign bus.out_valid = vld_r[NUM_STAGE-1];
   assign bus.dout      = res_s[DOUT_W-1:0];
   assign bus.sat       = res_s[DOUT_W];

   // Valid bits shift together with the data; a stall freezes the whole pipe.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         vld_r <= '0;
      end else if (adv_s) begin
         vld_r[0] <= bus.in_valid;
         for (int k = 1; k < NUM_STAGE; k++) begin
            vld_r[k] <= vld_r[k-1];
         end
      end
   end

   if (NUM_STAGE == 1) begin : g_single
      logic [DOUT_W:0] res_r;

      // Multiply, round and saturate all land in the only stage.
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            res_r <= '0;
         end else if (adv_s) begin
            res_r <= round_sat(prod_s);
         end
      end

      assign res_s = res_r;
   end else begin : g_multi
      logic signed [PW-1:0] prod_r;
      logic [DOUT_W:0]      res_r [NUM_STAGE-1];

      // Stage 1 holds the product, stage 2 the rounded result, later stages delay it.
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            prod_r <= '0;
            for (int k = 0; k < NUM_STAGE-1; k++) begin
               res_r[k] <= '0;
            end
         end else if (adv_s) begin
            prod_r   <= prod_s;
            res_r[0] <= round_sat(prod_r);
            for (int k = 1; k < NUM_STAGE-1; k++) begin
               res_r[k] <= res_r[k-1];
            end
         end
      end

      assign res_s = res_r[NUM_STAGE-2];
   end
endmodule

// File: tb/tb_constraint_layer_top_mul_pipe_rs.sv
// Directed bench: default configuration (2 stages, SHIFT=8, 16-bit out) plus an
// exact-product configuration (1 stage, SHIFT=0, 31-bit out, swapped signedness).
module tb_constraint_layer_top_mul_pipe_rs;
   logic ap_clk = 1'b0;
   logic ap_rst;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 ap_clk = ~ap_clk;

   constraint_layer_top_mul_pipe_rs_if #(.A_W(14), .B_W(16), .DOUT_W(16)) bus_a ();
   constraint_layer_top_mul_pipe_rs_if #(.A_W(14), .B_W(16), .DOUT_W(31)) bus_b ();

   constraint_layer_top_mul_pipe_rs #(
      .A_W(14), .B_W(16), .A_SIGNED(0), .B_SIGNED(1),
      .NUM_STAGE(2), .SHIFT(8), .DOUT_W(16)
   ) dut_a (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus_a)
   );

   constraint_layer_top_mul_pipe_rs #(
      .A_W(14), .B_W(16), .A_SIGNED(1), .B_SIGNED(0),
      .NUM_STAGE(1), .SHIFT(0), .DOUT_W(31)
   ) dut_b (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus_b)
   );

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   // One isolated pair through the 2-stage instance.
   task automatic one_a(input string tag, input int a, input int b, input int exp_d, input int exp_s);
      bus_a.din0     = 14'(a);
      bus_a.din1     = 16'(b);
      bus_a.in_valid = 1'b1;
      step();
      bus_a.in_valid = 1'b0;
      chk({tag, "_early"}, bus_a.out_valid, 0);
      step();
      chk({tag, "_valid"}, bus_a.out_valid, 1);
      chk({tag, "_dout"}, $signed(bus_a.dout), exp_d);
      chk({tag, "_sat"}, bus_a.sat, exp_s);
   endtask

   // One isolated pair through the 1-stage instance.
   task automatic one_b(input string tag, input int a, input int b, input int exp_d);
      bus_b.din0     = 14'(a);
      bus_b.din1     = 16'(b);
      bus_b.in_valid = 1'b1;
      step();
      bus_b.in_valid = 1'b0;
      chk({tag, "_valid"}, bus_b.out_valid, 1);
      chk({tag, "_dout"}, $signed(bus_b.dout), exp_d);
      chk({tag, "_sat"}, bus_b.sat, 0);
      step();
      chk({tag, "_drain"}, bus_b.out_valid, 0);
   endtask

   initial begin
      ap_rst          = 1'b1;
      bus_a.in_valid  = 1'b0;
      bus_a.din0      = 14'd0;
      bus_a.din1      = 16'd0;
      bus_a.out_ready = 1'b1;
      bus_b.in_valid  = 1'b0;
      bus_b.din0      = 14'd0;
      bus_b.din1      = 16'd0;
      bus_b.out_ready = 1'b1;
      step();
      step();
      chk("rst_a_valid", bus_a.out_valid, 0);
      chk("rst_a_dout", bus_a.dout, 0);
      chk("rst_a_sat", bus_a.sat, 0);
      chk("rst_b_valid", bus_b.out_valid, 0);
      chk("rst_b_dout", bus_b.dout, 0);
      ap_rst = 1'b0;
      #1;
      chk("rst_a_ready", bus_a.in_ready, 1);
      chk("rst_b_ready", bus_b.in_ready, 1);

      // Basic product and half-up rounding, both signs.
      one_a("a_256x300", 256, 300, 300, 0);
      one_a("a_r128", 1, 128, 1, 0);
      one_a("a_r127", 1, 127, 0, 0);
      one_a("a_rm128", 1, -128, 0, 0);
      one_a("a_rm129", 1, -129, -1, 0);
      one_a("a_satmin", 16383, -32768, -32768, 1);
      one_a("a_satmax", 16383, 32767, 32767, 1);
      step();

      // Eight back-to-back pairs: outputs on 8 consecutive cycles, in order.
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            bus_a.din0     = 14'd512;
            bus_a.din1     = 16'(100 * i - 350);
            bus_a.in_valid = 1'b1;
         end else begin
            bus_a.in_valid = 1'b0;
         end
         step();
         chk("a_stream_ready", bus_a.in_ready, 1);
         chk("a_stream_valid", bus_a.out_valid, (i >= 1 && i <= 8));
         if (i >= 1 && i <= 8) begin
            chk("a_stream_dout", $signed(bus_a.dout), 200 * (i - 1) - 700);
         end
      end

      // Back-pressure: hold three cycles, then drain with nothing lost.
      bus_a.din0     = 14'd512;
      bus_a.din1     = 16'd1000;
      bus_a.in_valid = 1'b1;
      step();
      bus_a.din1 = 16'd1001;
      step();
      chk("a_stall_first", $signed(bus_a.dout), 2000);
      bus_a.din1      = 16'd1002;
      bus_a.out_ready = 1'b0;
      #1;
      chk("a_stall_ready0", bus_a.in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("a_stall_valid", bus_a.out_valid, 1);
         chk("a_stall_dout", $signed(bus_a.dout), 2000);
         chk("a_stall_sat", bus_a.sat, 0);
         chk("a_stall_ready", bus_a.in_ready, 0);
      end
      bus_a.out_ready = 1'b1;
      #1;
      chk("a_release_ready", bus_a.in_ready, 1);
      step();
      bus_a.in_valid = 1'b0;
      chk("a_release_1", $signed(bus_a.dout), 2002);
      chk("a_release_1v", bus_a.out_valid, 1);
      step();
      chk("a_release_2", $signed(bus_a.dout), 2004);
      chk("a_release_2v", bus_a.out_valid, 1);
      step();
      chk("a_release_end", bus_a.out_valid, 0);

      // Reset with two pairs in flight discards both.
      bus_a.din1     = 16'd50;
      bus_a.in_valid = 1'b1;
      step();
      bus_a.din1 = 16'd60;
      step();
      bus_a.in_valid = 1'b0;
      ap_rst         = 1'b1;
      step();
      ap_rst = 1'b0;
      chk("a_midrst_valid", bus_a.out_valid, 0);
      chk("a_midrst_dout", bus_a.dout, 0);
      chk("a_midrst_sat", bus_a.sat, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("a_midrst_stale", bus_a.out_valid, 0);
      end
      one_a("a_after_rst", 512, 77, 154, 0);
      step();
      chk("a_after_rst_end", bus_a.out_valid, 0);

      // Exact-product configuration.
      one_b("b_256x300", 256, 300, 76800);
      one_b("b_1x128", 1, 128, 128);
      one_b("b_1x127", 1, 127, 127);
      one_b("b_1xm128", 1, -128, 65408);
      one_b("b_1xm129", 1, -129, 65407);
      one_b("b_m1x128", -1, 128, -128);
      one_b("b_16383xm32768", 16383, -32768, -32768);
      one_b("b_16383x32767", 16383, 32767, -32767);
      one_b("b_minxmax", -8192, 65535, -536862720);
      one_b("b_maxxmax", 8191, 65535, 536797185);

      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            bus_b.din0     = 14'(i - 4);
            bus_b.din1     = 16'd1000;
            bus_b.in_valid = 1'b1;
         end else begin
            bus_b.in_valid = 1'b0;
         end
         step();
         chk("b_stream_valid", bus_b.out_valid, (i < 8));
         if (i < 8) begin
            chk("b_stream_dout", $signed(bus_b.dout), (i - 4) * 1000);
            chk("b_stream_sat", bus_b.sat, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
